alu_arbiter: RTL

//  Shares one registered ALU datapath (AluB: A, B, op[2:0] -> Res, Zflag) between two requesters.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_arbiter_if.sv | 31 +++
 rtl/rr_arb2.sv | 15 +
 rtl/alu_arbiter.sv | 121 ++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: opcodes, FSM states and illegal-opcode decode.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_AND = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // 3'b110 and 3'b111 have no ALU function.
    function automatic logic op_is_illegal(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester, response and ALU-side signals of the arbiter; slave = arbiter, master = surroundings.
interface alu_arbiter_if #(
    parameter int W = 32
);
    logic [1:0]     req_valid;
    logic [1:0]     req_ready;
    logic [2*W-1:0] req_a;
    logic [2*W-1:0] req_b;
    logic [5:0]     req_op;
    logic [1:0]     rsp_valid;
    logic [1:0]     rsp_ready;
    logic [W-1:0]   rsp_data;
    logic           rsp_zero;
    logic           rsp_err;
    logic           busy;
    logic [W-1:0]   alu_a;
    logic [W-1:0]   alu_b;
    logic [2:0]     alu_op;
    logic [W-1:0]   alu_res;
    logic           alu_zflag;

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready, alu_res, alu_zflag,
        output req_ready, rsp_valid, rsp_data, rsp_zero, rsp_err, busy, alu_a, alu_b, alu_op
    );

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready, alu_res, alu_zflag,
        input  req_ready, rsp_valid, rsp_data, rsp_zero, rsp_err, busy, alu_a, alu_b, alu_op
    );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester wins; on a tie the one that was not served last wins.
module rr_arb2 (
    input  logic [1:0] valid_i,
    input  logic       last_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = valid_i;
        if (valid_i == 2'b11) begin
            grant_o = last_i ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered ALU between two requesters with round-robin grant and held responses.
// Optional macro ALU_ARB_ERR_EN: opcodes 110/111 bypass the ALU and return an error response.
import alu_pkg::*;

module alu_arbiter #(
    parameter int W       = 32,
    parameter int ALU_LAT = 1
) (
    input  logic          CLK,
    input  logic          RST,
    alu_arbiter_if.slave  bus
);

    localparam int CW = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);

    state_t         state_q;
    logic           last_q;
    logic           owner_q;
    logic [CW-1:0]  cnt_q;
    logic [1:0]     rsp_valid_q;
    logic [W-1:0]   rsp_data_q;
    logic           rsp_zero_q;
    logic           rsp_err_q;
    logic [W-1:0]   alu_a_q;
    logic [W-1:0]   alu_b_q;
    logic [2:0]     alu_op_q;

    logic [1:0]     grant_d;
    logic           g_idx;
    logic [W-1:0]   sel_a;
    logic [W-1:0]   sel_b;
    logic [2:0]     sel_op;
    logic           err_op;

    rr_arb2 u_rr_arb2 (
        .valid_i (bus.req_valid),
        .last_i  (last_q),
        .grant_o (grant_d)
    );

    always_comb begin
        g_idx  = grant_d[1];
        sel_a  = g_idx ? bus.req_a[2*W-1:W] : bus.req_a[W-1:0];
        sel_b  = g_idx ? bus.req_b[2*W-1:W] : bus.req_b[W-1:0];
        sel_op = g_idx ? bus.req_op[5:3]    : bus.req_op[2:0];
`ifdef ALU_ARB_ERR_EN
        err_op = op_is_illegal(sel_op);
`else
        err_op = 1'b0;
`endif
    end

    // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            last_q      <= 1'b1;
            owner_q     <= 1'b0;
            cnt_q       <= '0;
            rsp_valid_q <= 2'b00;
            rsp_data_q  <= '0;
            rsp_zero_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= OP_ADD;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (grant_d != 2'b00) begin
                        owner_q <= g_idx;
                        cnt_q   <= '0;
                        if (err_op) begin
                            rsp_valid_q <= grant_d;
                            rsp_data_q  <= '0;
                            rsp_zero_q  <= 1'b0;
                            rsp_err_q   <= 1'b1;
                            state_q     <= ST_RESP;
                        end else begin
                            alu_a_q  <= sel_a;
                            alu_b_q  <= sel_b;
                            alu_op_q <= sel_op;
                            state_q  <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    // Operands have been stable for ALU_LAT edges once cnt reaches ALU_LAT.
                    if (cnt_q == CW'(ALU_LAT)) begin
                        rsp_data_q  <= bus.alu_res;
                        rsp_zero_q  <= bus.alu_zflag;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= owner_q ? 2'b10 : 2'b01;
                        state_q     <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready[owner_q]) begin
                        rsp_valid_q <= 2'b00;
                        last_q      <= owner_q;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready = (state_q == ST_IDLE && !RST) ? grant_d : 2'b00;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_zero  = rsp_zero_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_op    = alu_op_q;

endmodule
